// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing one frame_transmission engine between NUM_REQ sources,
// with inter-frame gap insertion and a SEND-state watchdog.
module tx_frame_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_W     = 32,
    parameter int IFG_CYCLES = 12,
    parameter int TIMEOUT    = 1024,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sched_en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      timeout_err,
    output logic                      busy,
    output logic [ID_W-1:0]           active_id,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_en,
    input  logic                      tx_done
);

    localparam int WD_W  = $clog2(TIMEOUT);
    localparam int IFG_W = $clog2(IFG_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_CYCLES - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]    NREQ_L   = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_IFG  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic [IFG_W-1:0]    ifg_cnt_q, ifg_cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic [ID_W-1:0]     active_id_q, active_id_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_en_q, tx_en_d;

    logic [ID_W-1:0]     winner_s;
    logic                found_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                start_s;
    logic                wd_expire_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] oh;
        oh = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            oh[k] = (id == ID_W'(k));
        end
        return oh;
    endfunction

    // Rotating priority search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W:0] idx;
        logic          hit;
        winner_s = rr_ptr_q;
        found_s  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx      = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
            idx      = (idx >= NREQ_L) ? (idx - NREQ_L) : idx;
            hit      = !found_s && req[idx[ID_W-1:0]];
            winner_s = hit ? idx[ID_W-1:0] : winner_s;
            found_s  = found_s | hit;
        end
    end

    // Word of the winning source.
    always_comb begin
        sel_data_s = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_data_s = (winner_s == ID_W'(k)) ? req_data[k*DATA_W +: DATA_W] : sel_data_s;
        end
    end

    assign start_s     = sched_en && found_s;
    assign wd_expire_s = (wd_cnt_q == WD_LAST);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= {ID_W{1'b0}};
            wd_cnt_q    <= {WD_W{1'b0}};
            ifg_cnt_q   <= {IFG_W{1'b0}};
            grant_q     <= {NUM_REQ{1'b0}};
            done_q      <= {NUM_REQ{1'b0}};
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            active_id_q <= {ID_W{1'b0}};
            tx_data_q   <= {DATA_W{1'b0}};
            tx_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            wd_cnt_q    <= wd_cnt_d;
            ifg_cnt_q   <= ifg_cnt_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            active_id_q <= active_id_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tx_done || wd_expire_s) begin
                    state_d = ST_IFG;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_IFG: begin
                if (ifg_cnt_q == {IFG_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_IFG;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and counter next values; tx_done takes priority over the watchdog.
    always_comb begin
        grant_d     = {NUM_REQ{1'b0}};
        done_d      = {NUM_REQ{1'b0}};
        timeout_d   = 1'b0;
        tx_en_d     = tx_en_q;
        tx_data_d   = tx_data_q;
        active_id_d = active_id_q;
        rr_ptr_d    = rr_ptr_q;
        wd_cnt_d    = wd_cnt_q;
        ifg_cnt_d   = ifg_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    tx_data_d   = sel_data_s;
                    tx_en_d     = 1'b1;
                    grant_d     = onehot(winner_s);
                    active_id_d = winner_s;
                    rr_ptr_d    = (winner_s == ID_LAST) ? {ID_W{1'b0}} : (winner_s + 1'b1);
                    wd_cnt_d    = {WD_W{1'b0}};
                end else begin
                    tx_en_d     = 1'b0;
                end
            end
            ST_SEND: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                if (tx_done) begin
                    tx_en_d   = 1'b0;
                    done_d    = onehot(active_id_q);
                    ifg_cnt_d = IFG_LOAD;
                end else if (wd_expire_s) begin
                    tx_en_d   = 1'b0;
                    timeout_d = 1'b1;
                    ifg_cnt_d = IFG_LOAD;
                end else begin
                    tx_en_d   = 1'b1;
                end
            end
            ST_IFG: begin
                tx_en_d   = 1'b0;
                ifg_cnt_d = (ifg_cnt_q == {IFG_W{1'b0}}) ? {IFG_W{1'b0}} : (ifg_cnt_q - 1'b1);
            end
            default: begin
                tx_en_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign busy        = busy_q;
    assign active_id   = active_id_q;
    assign tx_data     = tx_data_q;
    assign tx_en       = tx_en_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Self-checking bench for tx_frame_scheduler: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_tx_frame_scheduler;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int IFG  = 12;
    localparam int TMO  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sched_en = 1'b0;
    logic [1:0]        req = 2'b00;
    logic [63:0]       req_data = 64'd0;
    logic              tx_done = 1'b0;
    logic [1:0]        grant;
    logic [1:0]        done;
    logic              timeout_err;
    logic              busy;
    logic [0:0]        active_id;
    logic [31:0]       tx_data;
    logic              tx_en;

    int errors = 0;
    int checks = 0;

    tx_frame_scheduler #(
        .NUM_REQ(NREQ), .DATA_W(DW), .IFG_CYCLES(IFG), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .timeout_err(timeout_err), .busy(busy),
        .active_id(active_id), .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  rq;
        logic        dn;
        logic [31:0] d0;
        logic [1:0]  e_grant;
        logic [1:0]  e_done;
        logic        e_busy;
        logic        e_txen;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state: mode 0 idle, 1 sending, 2 gap.
    int          m_mode, m_rr, m_owner, m_age, m_gap;
    logic [1:0]  e_grant, e_done;
    logic        e_to, e_busy, e_txen;
    logic [0:0]  e_id;
    logic [31:0] e_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outv();
        return {24'd0, grant, done, timeout_err, busy, active_id, tx_en, tx_data};
    endfunction

    function automatic logic [63:0] expv();
        return {24'd0, e_grant, e_done, e_to, e_busy, e_id, e_txen, e_data};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sched_en = 1'b0; req = 2'b00; tx_done = 1'b0; req_data = 64'd0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic void add(input logic en, input logic [1:0] rq, input logic dn,
                                input logic [31:0] d0, input logic [1:0] eg, input logic [1:0] ed,
                                input logic eb, input logic et, input logic [31:0] edat);
        vec_t v;
        v.en = en; v.rq = rq; v.dn = dn; v.d0 = d0;
        v.e_grant = eg; v.e_done = ed; v.e_busy = eb; v.e_txen = et; v.e_data = edat;
        tbl.push_back(v);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_rr = 0; m_owner = 0; m_age = 0; m_gap = 0;
        e_grant = 2'b00; e_done = 2'b00; e_to = 1'b0; e_busy = 1'b0;
        e_id = 1'b0; e_txen = 1'b0; e_data = 32'd0;
    endtask

    // Predicts the outputs visible after the next rising edge for the given inputs.
    task automatic model_step(input logic rn, input logic en, input logic [1:0] rq,
                              input logic dn, input logic [63:0] dat);
        int win;
        e_grant = 2'b00; e_done = 2'b00; e_to = 1'b0;
        if (!rn) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: begin
                win = -1;
                if (en) begin
                    for (int off = 0; off < NREQ; off++) begin
                        int i;
                        i = (m_rr + off) % NREQ;
                        if (win < 0 && rq[i]) win = i;
                    end
                end
                if (win >= 0) begin
                    e_grant[win] = 1'b1;
                    e_txen = 1'b1;
                    e_data = dat[win*32 +: 32];
                    e_id = win[0:0];
                    m_owner = win;
                    m_rr = (win + 1) % NREQ;
                    m_age = 1;
                    m_mode = 1;
                end
            end
            1: begin
                if (dn) begin
                    e_done[m_owner] = 1'b1;
                    e_txen = 1'b0; m_gap = 1; m_mode = 2;
                end else if (m_age == TMO) begin
                    e_to = 1'b1;
                    e_txen = 1'b0; m_gap = 1; m_mode = 2;
                end else begin
                    m_age++;
                end
            end
            default: begin
                if (m_gap == IFG) m_mode = 0;
                else m_gap++;
            end
        endcase
        e_busy = (m_mode != 0);
    endtask

    initial begin
        int low_cnt, bcnt, hi, to_cnt, dn_cnt;
        bit got, fell;
        logic [1:0] exp_g;

        // Directed table: single frame, IFG with a spurious tx_done, then sched_en gating.
        add(1'b1, 2'b01, 1'b0, 32'hAABBCCDD, 2'b01, 2'b00, 1'b1, 1'b1, 32'hAABBCCDD);
        add(1'b1, 2'b00, 1'b0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b1, 32'hAABBCCDD);
        add(1'b1, 2'b00, 1'b0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b1, 32'hAABBCCDD);
        add(1'b1, 2'b00, 1'b1, 32'h0, 2'b00, 2'b01, 1'b1, 1'b0, 32'hAABBCCDD);
        for (int i = 0; i < IFG - 1; i++)
            add(1'b1, 2'b00, (i == 5), 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, 32'hAABBCCDD);
        add(1'b1, 2'b00, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 32'hAABBCCDD);
        add(1'b0, 2'b01, 1'b1, 32'h11, 2'b00, 2'b00, 1'b0, 1'b0, 32'hAABBCCDD);
        add(1'b0, 2'b01, 1'b0, 32'h11, 2'b00, 2'b00, 1'b0, 1'b0, 32'hAABBCCDD);
        add(1'b0, 2'b01, 1'b1, 32'h11, 2'b00, 2'b00, 1'b0, 1'b0, 32'hAABBCCDD);
        add(1'b1, 2'b01, 1'b0, 32'h12345678, 2'b01, 2'b00, 1'b1, 1'b1, 32'h12345678);
        add(1'b1, 2'b00, 1'b1, 32'h0, 2'b00, 2'b01, 1'b1, 1'b0, 32'h12345678);

        rst_n = 1'b0;
        step();
        chk("reset_state", outv(), 64'd0);
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            sched_en = tbl[i].en; req = tbl[i].rq; tx_done = tbl[i].dn;
            req_data = {32'hDEADBEEF, tbl[i].d0};
            step();
            chk($sformatf("vec%0d", i), outv(),
                {24'd0, tbl[i].e_grant, tbl[i].e_done, 1'b0, tbl[i].e_busy, 1'b0,
                 tbl[i].e_txen, tbl[i].e_data});
        end

        // Simultaneous requests: alternating order and a 13-cycle gap between frames.
        do_reset();
        sched_en = 1'b1; req = 2'b11; req_data = {32'h22222222, 32'h11111111};
        low_cnt = 0;
        for (int f = 0; f < 4; f++) begin
            got = 1'b0;
            for (int t = 0; t < 30 && !got; t++) begin
                step();
                if (grant != 2'b00) got = 1'b1;
                else if (!tx_en) low_cnt++;
            end
            exp_g = (f % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("order_grant%0d", f), {62'd0, grant}, {62'd0, exp_g});
            if (f > 0) chk($sformatf("ifg_gap%0d", f), low_cnt, 13);
            if (f == 3) req = 2'b00;
            step();
            step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            chk($sformatf("order_done%0d", f), {62'd0, done}, {62'd0, exp_g});
            low_cnt = tx_en ? 0 : 1;
        end
        bcnt = busy ? 1 : 0;
        got = 1'b0;
        for (int t = 0; t < 30 && !got; t++) begin
            step();
            if (busy) bcnt++;
            else got = 1'b1;
        end
        chk("busy_tail", bcnt, IFG);

        // Watchdog abort and hand-over to the other source.
        do_reset();
        sched_en = 1'b1; req = 2'b01;
        step();
        chk("to_grant", {62'd0, grant}, 64'd1);
        req = 2'b11;
        hi = tx_en ? 1 : 0; to_cnt = 0; dn_cnt = 0; fell = 1'b0;
        for (int t = 0; t < 40 && !fell; t++) begin
            step();
            to_cnt += timeout_err; dn_cnt += (done != 2'b00);
            if (tx_en) hi++;
            else fell = 1'b1;
        end
        chk("to_len", hi, TMO);
        chk("to_pulse", {63'd0, timeout_err}, 64'd1);
        got = 1'b0;
        for (int t = 0; t < 30 && !got; t++) begin
            step();
            to_cnt += timeout_err; dn_cnt += (done != 2'b00);
            if (grant != 2'b00) got = 1'b1;
        end
        chk("to_count", to_cnt, 1);
        chk("to_no_done", dn_cnt, 0);
        chk("to_next", {62'd0, grant}, 64'd2);

        // Reset in the middle of a frame.
        do_reset();
        sched_en = 1'b1; req = 2'b01;
        step();
        req = 2'b00;
        step();
        chk("pre_rst_txen", {63'd0, tx_en}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", outv(), 64'd0);
        step();
        chk("rst_hold", outv(), 64'd0);
        rst_n = 1'b1; req = 2'b11;
        step();
        chk("rst_rr", {62'd0, grant}, 64'd1);

        // Randomized run against the model.
        do_reset();
        model_reset();
        req = 2'b00;
        for (int c = 0; c < 2500; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            sched_en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NREQ; i++)
                if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
            tx_done = (m_mode == 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
            req_data = {$urandom(), $urandom()};
            model_step(rst_n, sched_en, req, tx_done, req_data);
            step();
            chk($sformatf("rand%0d", c), outv(), expv());
            for (int i = 0; i < NREQ; i++)
                if (e_grant[i]) req[i] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
